// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Multi-cycle execute unit. Logic/arithmetic ops complete in one cycle; shifts
//   iterate on a serial 1-bit-per-cycle shifter. Results are returned over a
//   valid/ready handshake and held stable until accepted.
//
//   Optional build macro: ALU_SLTU_EN
//     defined   -> alu_ctrl 1001 decodes as SLTU (unsigned set-less-than)
//     undefined -> 1001 is an undefined code (result 0, zero 1)
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   request valid          in_ready  unit can accept a request
//     alu_ctrl   4-bit operation code
//     op_a       first operand / shift source
//     op_b       second operand; op_b[SHW-1:0] is the shift amount
//     out_valid  result valid           out_ready consumer accepts result
//     result     operation result       zero      result == 0 (with out_valid)
//     busy       high while a shift is iterating
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for a request, in_ready=1
//   S_SHIFT | serial shifter running, one bit per cycle, busy=1
//   S_DONE  | result presented, out_valid=1, waiting for out_ready
// -----------------------------------------------------------------------------
module alu_exec_unit #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
`ifdef ALU_SLTU_EN
   localparam logic [3:0] OP_SLTU = 4'b1001;
`endif

   state_t            state_q, state_d;
   logic [XLEN-1:0]   shift_q, shift_d;
   logic [SHW-1:0]    cnt_q, cnt_d;
   logic [1:0]        sh_op_q, sh_op_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              zero_q, zero_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;

   logic [XLEN-1:0]   alu_res;
   logic [XLEN-1:0]   shift_next;
   logic [SHW-1:0]    shamt;
   logic              is_shift;

   assign shamt    = op_b[SHW-1:0];
   assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

   // Single-cycle datapath; shift codes never use this value.
   always_comb begin
      alu_res = '0;
      case (alu_ctrl)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_SLTU_EN
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`endif
         default: alu_res = '0;
      endcase
   end

   // sh_op holds alu_ctrl[1:0] of the accepted shift: 01 SLL, 10 SRL, 11 SRA.
   always_comb begin
      shift_next = shift_q;
      case (sh_op_q)
         2'b01:   shift_next = {shift_q[XLEN-2:0], 1'b0};
         2'b10:   shift_next = {1'b0, shift_q[XLEN-1:1]};
         default: shift_next = {shift_q[XLEN-1], shift_q[XLEN-1:1]};
      endcase
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      sh_op_d     = sh_op_q;
      result_d    = result_q;
      zero_d      = zero_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               in_ready_d = 1'b0;
               if (is_shift) begin
                  shift_d = op_a;
                  cnt_d   = shamt;
                  sh_op_d = alu_ctrl[1:0];
                  if (shamt == '0) begin
                     result_d    = op_a;
                     zero_d      = (op_a == '0);
                     out_valid_d = 1'b1;
                     state_d     = S_DONE;
                  end else begin
                     busy_d  = 1'b1;
                     state_d = S_SHIFT;
                  end
               end else begin
                  result_d    = alu_res;
                  zero_d      = (alu_res == '0);
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            shift_d = shift_next;
            cnt_d   = cnt_q - SHW'(1);
            // cnt==1 means this edge performs the last shift
            if (cnt_q == SHW'(1)) begin
               result_d    = shift_next;
               zero_d      = (shift_next == '0);
               busy_d      = 1'b0;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         sh_op_q     <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         sh_op_q     <= sh_op_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign busy      = busy_q;

endmodule
